// File: rtl/stopwatch_btn.sv
// Button conditioning for the stopwatch core: per-button two-flop synchronizer,
// debounce counter and registered press-edge pulse. Run/stop and clear/split
// paths are identical and share nothing except the clock and reset.
module stopwatch_btn #(
    parameter int unsigned DBN = 24000,  // debounce length in clock periods, >= 1
    parameter bit          POL = 1'b1    // raw active level: 1 = active-high
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    input  logic i_clr,
    output logic b_run,
    output logic b_clr,
    output logic p_run,
    output logic p_clr
);

    localparam int unsigned CW = (DBN < 1) ? 1 : $clog2(DBN + 1);
    localparam logic [CW-1:0] DbnM1 = CW'(DBN - 1);

    // Encoding is {lvl, counting}: bit 1 is the debounced level.
    typedef enum logic [1:0] {
        StIdle        = 2'b00,
        StPressWait   = 2'b01,
        StPressed     = 2'b10,
        StReleaseWait = 2'b11
    } st_e;

    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] pls;

    assign raw = {i_clr, i_run};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          n;
        logic          s1_q;
        logic          s2_q;
        logic          p_q;
        logic          p_d;
        st_e           st_q;
        st_e           st_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;

        // Normalise to active-high before the synchronizer.
        assign n = POL ? raw[g] : ~raw[g];

        // State, synchronizer and pulse registers; reset discards any count in progress.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                st_q  <= StIdle;
                cnt_q <= '0;
                p_q   <= 1'b0;
            end else begin
                s1_q  <= n;
                s2_q  <= s1_q;
                st_q  <= st_d;
                cnt_q <= cnt_d;
                p_q   <= p_d;
            end
        end

        // Debounce: level flips only after s2 differs from it for DBN consecutive cycles.
        always_comb begin
            st_d  = st_q;
            cnt_d = cnt_q;
            p_d   = 1'b0;
            unique case (st_q)
                StIdle, StPressWait: begin
                    if (!s2_q) begin
                        st_d  = StIdle;
                        cnt_d = '0;
                    end else if (cnt_q == DbnM1) begin
                        st_d  = StPressed;
                        cnt_d = '0;
                        p_d   = 1'b1;  // lands with the first high cycle of the level
                    end else begin
                        st_d  = StPressWait;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                StPressed, StReleaseWait: begin
                    if (s2_q) begin
                        st_d  = StPressed;
                        cnt_d = '0;
                    end else if (cnt_q == DbnM1) begin
                        st_d  = StIdle;
                        cnt_d = '0;
                    end else begin
                        st_d  = StReleaseWait;
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    st_d  = StIdle;
                    cnt_d = '0;
                end
            endcase
        end

        assign lvl[g] = (st_q == StPressed) || (st_q == StReleaseWait);
        assign pls[g] = p_q;
    end

    assign b_run = lvl[0];
    assign b_clr = lvl[1];
    assign p_run = pls[0];
    assign p_clr = pls[1];

endmodule

// File: tb/tb_stopwatch_btn.sv
// Self-checking bench for stopwatch_btn. Stimulus is a table of segments (inputs held for
// len cycles with the outputs expected during those cycles); expectations are queued as
// inputs are driven and popped once the DUT has clocked them in.
module tb_stopwatch_btn;

    typedef struct packed {
        logic       rst;
        logic       run;
        logic       clr;
        logic [7:0] len;
        logic [3:0] exp;  // {b_run, b_clr, p_run, p_clr}
    } seg_t;

    typedef struct packed {
        logic [3:0] exp;
        logic [7:0] seg;
    } sb_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1, run_a = 1'b0, clr_a = 1'b0;
    logic rst_b = 1'b1, run_b = 1'b1, clr_b = 1'b1;
    logic b_run_a, b_clr_a, p_run_a, p_clr_a;
    logic b_run_b, b_clr_b, p_run_b, p_clr_b;

    int checks   = 0;
    int failures = 0;
    seg_t tab_a[$];
    seg_t tab_b[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    stopwatch_btn #(.DBN(4), .POL(1'b1)) u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .i_run (run_a),
        .i_clr (clr_a),
        .b_run (b_run_a),
        .b_clr (b_clr_a),
        .p_run (p_run_a),
        .p_clr (p_clr_a)
    );

    stopwatch_btn #(.DBN(4), .POL(1'b0)) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .i_run (run_b),
        .i_clr (clr_b),
        .b_run (b_run_b),
        .b_clr (b_clr_b),
        .p_run (p_run_b),
        .p_clr (p_clr_b)
    );

    function automatic seg_t mk(input logic r, input logic ru, input logic cl, input int n,
                                input logic [3:0] e);
        seg_t s;
        s.rst = r;
        s.run = ru;
        s.clr = cl;
        s.len = 8'(n);
        s.exp = e;
        return s;
    endfunction

    task automatic chk(input string tag, input int seg, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s seg=%0d t=%0t got=%b want=%b", tag, seg, $time, got, want);
        end
    endtask

    // Drive one segment on the chosen DUT, comparing every cycle against the scoreboard.
    task automatic apply(input seg_t s, input int idx, input bit on_b);
        sb_t e;
        logic [3:0] got;
        for (int c = 0; c < int'(s.len); c++) begin
            @(negedge clk);
            if (on_b) begin
                rst_b = s.rst; run_b = s.run; clr_b = s.clr;
            end else begin
                rst_a = s.rst; run_a = s.run; clr_a = s.clr;
            end
            sb.push_back('{exp: s.exp, seg: 8'(idx)});
            @(posedge clk);
            #1;
            e   = sb.pop_front();
            got = on_b ? {b_run_b, b_clr_b, p_run_b, p_clr_b}
                       : {b_run_a, b_clr_a, p_run_a, p_clr_a};
            chk(on_b ? "b_run(pol0)" : "b_run", int'(e.seg), got[3], e.exp[3]);
            chk(on_b ? "b_clr(pol0)" : "b_clr", int'(e.seg), got[2], e.exp[2]);
            chk(on_b ? "p_run(pol0)" : "p_run", int'(e.seg), got[1], e.exp[1]);
            chk(on_b ? "p_clr(pol0)" : "p_clr", int'(e.seg), got[0], e.exp[0]);
        end
    endtask

    initial begin
        // rst run clr len {b_run b_clr p_run p_clr}; DBN=4, POL=1
        // Reset with both buttons held, then both debounce in together.
        tab_a.push_back(mk(1, 1, 1, 2,  4'b0000));
        tab_a.push_back(mk(0, 1, 1, 5,  4'b0000));
        tab_a.push_back(mk(0, 1, 1, 1,  4'b1111));  // edge 6 after reset
        tab_a.push_back(mk(0, 1, 1, 1,  4'b1100));
        tab_a.push_back(mk(0, 0, 0, 5,  4'b1100));
        tab_a.push_back(mk(0, 0, 0, 3,  4'b0000));
        // Clean run press and release.
        tab_a.push_back(mk(0, 1, 0, 5,  4'b0000));
        tab_a.push_back(mk(0, 1, 0, 1,  4'b1010));
        tab_a.push_back(mk(0, 1, 0, 14, 4'b1000));
        tab_a.push_back(mk(0, 0, 0, 5,  4'b1000));
        tab_a.push_back(mk(0, 0, 0, 3,  4'b0000));
        // Clear bounce 1,0,1,1,0,1,1,1,0 then stable high.
        tab_a.push_back(mk(0, 0, 1, 1,  4'b0000));
        tab_a.push_back(mk(0, 0, 0, 1,  4'b0000));
        tab_a.push_back(mk(0, 0, 1, 2,  4'b0000));
        tab_a.push_back(mk(0, 0, 0, 1,  4'b0000));
        tab_a.push_back(mk(0, 0, 1, 3,  4'b0000));
        tab_a.push_back(mk(0, 0, 0, 1,  4'b0000));
        tab_a.push_back(mk(0, 0, 1, 5,  4'b0000));
        tab_a.push_back(mk(0, 0, 1, 1,  4'b0101));
        tab_a.push_back(mk(0, 0, 1, 3,  4'b0100));
        tab_a.push_back(mk(0, 0, 0, 5,  4'b0100));
        tab_a.push_back(mk(0, 0, 0, 2,  4'b0000));
        // 3-cycle run glitch is filtered.
        tab_a.push_back(mk(0, 1, 0, 3,  4'b0000));
        tab_a.push_back(mk(0, 0, 0, 8,  4'b0000));
        // Press, 3-cycle dip while pressed, release.
        tab_a.push_back(mk(0, 1, 0, 5,  4'b0000));
        tab_a.push_back(mk(0, 1, 0, 1,  4'b1010));
        tab_a.push_back(mk(0, 1, 0, 3,  4'b1000));
        tab_a.push_back(mk(0, 0, 0, 3,  4'b1000));
        tab_a.push_back(mk(0, 1, 0, 8,  4'b1000));
        tab_a.push_back(mk(0, 0, 0, 5,  4'b1000));
        tab_a.push_back(mk(0, 0, 0, 3,  4'b0000));
        // Simultaneous press and release.
        tab_a.push_back(mk(0, 1, 1, 5,  4'b0000));
        tab_a.push_back(mk(0, 1, 1, 1,  4'b1111));
        tab_a.push_back(mk(0, 1, 1, 3,  4'b1100));
        tab_a.push_back(mk(0, 0, 0, 5,  4'b1100));
        tab_a.push_back(mk(0, 0, 0, 2,  4'b0000));

        // POL=0: idle is 1, press is 0; reset lands two cycles into the press wait.
        tab_b.push_back(mk(1, 1, 1, 2,  4'b0000));
        tab_b.push_back(mk(0, 1, 1, 4,  4'b0000));
        tab_b.push_back(mk(0, 0, 1, 3,  4'b0000));
        tab_b.push_back(mk(1, 0, 1, 2,  4'b0000));
        tab_b.push_back(mk(0, 0, 1, 5,  4'b0000));  // would have risen here without reset
        tab_b.push_back(mk(0, 0, 1, 1,  4'b1010));
        tab_b.push_back(mk(0, 0, 1, 3,  4'b1000));
        tab_b.push_back(mk(0, 1, 1, 5,  4'b1000));
        tab_b.push_back(mk(0, 1, 1, 2,  4'b0000));

        foreach (tab_a[i]) apply(tab_a[i], i, 1'b0);
        foreach (tab_b[i]) apply(tab_b[i], i, 1'b1);

        // Every queued expectation must have been consumed.
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
